// File: rtl/rom_arbiter_rr_pkg.sv
// Shared constants and helpers for the ROM/RAM read arbiters.
package rom_arbiter_rr_pkg;

  localparam int unsigned ARB_FIXED = 0;
  localparam int unsigned ARB_RR    = 1;

  // Ceiling log2 with a floor of one bit so a 1-bit index always exists.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned res;
    res = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((32'd1 << i) < value) res = i + 1;
    end
    return (res == 0) ? 1 : res;
  endfunction

endpackage

// File: rtl/rom_arbiter_rr_prio_pick.sv
// Rotating priority picker: first set request at or above start, wrapping at PORT_NUM.
module rr_prio_pick
  import rom_arbiter_rr_pkg::*;
#(
  parameter int unsigned PORT_NUM = 4,
  parameter int unsigned IDX_W    = clog2(PORT_NUM)
) (
  input  logic [PORT_NUM-1:0] req,
  input  logic [IDX_W-1:0]    start,
  output logic [PORT_NUM-1:0] grant_c,
  output logic [IDX_W-1:0]    idx_c
);

  logic [IDX_W:0]   sum;
  logic [IDX_W-1:0] pos;
  logic             found;

  // Explicit subtract-on-overflow keeps non-power-of-two port counts correct.
  always_comb begin
    grant_c = '0;
    idx_c   = '0;
    found   = 1'b0;
    sum     = '0;
    pos     = '0;
    for (int unsigned off = 0; off < PORT_NUM; off++) begin
      sum = {1'b0, start} + (IDX_W+1)'(off);
      if (sum >= (IDX_W+1)'(PORT_NUM)) sum = sum - (IDX_W+1)'(PORT_NUM);
      pos = IDX_W'(sum);
      if (!found && req[pos]) begin
        found        = 1'b1;
        grant_c[pos] = 1'b1;
        idx_c        = pos;
      end
    end
  end

endmodule

// File: rtl/rom_arbiter_rr.sv
// Read arbiter for a shared ROM/SRAM port with a fixed-latency valid pipeline.
module rom_arbiter_rr
  import rom_arbiter_rr_pkg::*;
#(
  parameter int unsigned PORT_NUM   = 4,
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned RD_LATENCY = 1,
  parameter int unsigned ARB_MODE   = ARB_RR
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [PORT_NUM-1:0]            mem_rd_i,
  input  logic [PORT_NUM*ADDR_WIDTH-1:0] mem_addr_i,
  output logic [PORT_NUM-1:0]            mem_accept_o,
  output logic [PORT_NUM-1:0]            mem_valid_o,
  output logic [DATA_WIDTH-1:0]          mem_d4rd_o,
  output logic                           mem_rd_o,
  output logic [ADDR_WIDTH-1:0]          mem_addr_o,
  input  logic                           mem_accept_i,
  input  logic [DATA_WIDTH-1:0]          mem_d4rd_i
);

  localparam int unsigned IDX_W = clog2(PORT_NUM);

  logic [IDX_W-1:0]    ptr;
  logic [IDX_W-1:0]    ptr_nxt;
  logic [IDX_W-1:0]    start;
  logic [PORT_NUM-1:0] grant;
  logic [IDX_W-1:0]    idx;
  logic                xfer;

  assign start = (ARB_MODE == ARB_RR) ? ptr : '0;

  rr_prio_pick #(
    .PORT_NUM (PORT_NUM),
    .IDX_W    (IDX_W)
  ) u_pick (
    .req     (mem_rd_i),
    .start   (start),
    .grant_c (grant),
    .idx_c   (idx)
  );

  assign mem_rd_o     = |mem_rd_i;
  assign xfer         = mem_rd_o & mem_accept_i;
  assign mem_accept_o = grant & {PORT_NUM{mem_accept_i}};
  assign mem_d4rd_o   = mem_d4rd_i;

  // One-hot grant makes an OR-mux sufficient; no grant yields zero.
  always_comb begin
    mem_addr_o = '0;
    for (int unsigned k = 0; k < PORT_NUM; k++) begin
      if (grant[k]) mem_addr_o = mem_addr_o | mem_addr_i[k*ADDR_WIDTH +: ADDR_WIDTH];
    end
  end

  always_comb begin
    ptr_nxt = ptr;
    if ((ARB_MODE == ARB_RR) && xfer) begin
      ptr_nxt = (idx == IDX_W'(PORT_NUM - 1)) ? '0 : idx + IDX_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ptr <= '0;
    else     ptr <= ptr_nxt;
  end

  // Valid strobe shift register; stage 0 captures the accept of every cycle.
  for (genvar i = 0; i < int'(RD_LATENCY); i++) begin : g_vld
    logic [PORT_NUM-1:0] q;
    if (i == 0) begin : g_first
      always_ff @(posedge clk or posedge rst) begin
        if (rst) q <= '0;
        else     q <= mem_accept_o;
      end
    end else begin : g_next
      always_ff @(posedge clk or posedge rst) begin
        if (rst) q <= '0;
        else     q <= g_vld[i-1].q;
      end
    end
  end

  assign mem_valid_o = g_vld[RD_LATENCY-1].q;

endmodule

// File: doc/rom_arbiter_rr.md
# rom_arbiter_rr

Parametrised read arbiter between PORT_NUM requesters and one shared single-port ROM/SRAM read port. Selectable fixed-priority or round-robin arbitration. A registered grant pipeline returns a per-port read-data-valid strobe exactly RD_LATENCY cycles after each accepted read. It sits between the correlator/search-engine memory clients and the coefficient/code ROM, for memories whose read data arrives one or more cycles after the address.

## Interface
- PORT_NUM, 4, number of requesting ports (2..16, need not be a power of two)
- ADDR_WIDTH, 10, memory address width
- DATA_WIDTH, 32, memory data width
- RD_LATENCY, 1, cycles from accepted address to valid mem_d4rd_i (1..4)
- ARB_MODE, 1, 0 = fixed priority (port 0 highest), 1 = round-robin
- clk  input  1  clock, all state on rising edge
- rst  input  1  asynchronous, active-high reset
- mem_rd_i  input  PORT_NUM  per-port read request, bit k = port k
- mem_addr_i  input  PORT_NUM*ADDR_WIDTH  per-port address, port k at bits [k*ADDR_WIDTH +: ADDR_WIDTH]
- mem_accept_o  output  PORT_NUM  per-port accept, one-hot or zero
- mem_valid_o  output  PORT_NUM  per-port read-data-valid strobe, one-hot or zero
- mem_d4rd_o  output  DATA_WIDTH  read data, shared by all ports
- mem_rd_o  output  1  read request to memory
- mem_addr_o  output  ADDR_WIDTH  address to memory
- mem_accept_i  input  1  memory accepts the presented address this cycle
- mem_d4rd_i  input  DATA_WIDTH  memory read data

## Operation
- Request rule: a port holds mem_rd_i[k] high and mem_addr_i stable until it sees mem_accept_o[k] high. One accept equals one read.
- mem_rd_o = OR of mem_rd_i. Combinational.
- Grant (combinational): the first requesting port found by scanning from index ptr upward, wrapping PORT_NUM-1 → 0. In fixed mode ptr is constantly 0.
- mem_addr_o = address of the granted port. It is 0 when there are no requests.
- mem_accept_o[k] = grant[k] & mem_accept_i.
- Round-robin pointer ptr, width clog2(PORT_NUM):
  - On a transfer (mem_rd_o & mem_accept_i), ptr ← granted index + 1, with PORT_NUM-1 wrapping to 0. Explicit compare; no power-of-two wrap.
  - With no transfer, ptr holds.
  - ARB_MODE = 0: ptr is never updated.
- Valid pipeline: RD_LATENCY stages of PORT_NUM-bit one-hot.
  - Stage 0 ← mem_accept_o on every clock.
  - Stage i ← stage i-1.
  - mem_valid_o = last stage.
  - Back-to-back accepts are supported, one per cycle.
- mem_d4rd_o = mem_d4rd_i, unregistered.

## Timing
- Reset values: ptr = 0, all pipeline stages = 0, mem_valid_o = 0.
- mem_rd_o, mem_addr_o and mem_accept_o are combinational from their inputs. No reset value applies to them.
- Latency: accept sampled at edge N; mem_valid_o[k] is high in cycle N+RD_LATENCY, together with valid data on mem_d4rd_o.
- mem_accept_i low: no accept to any port, ptr holds, pipeline shifts in zero.
- All ports requesting continuously in round-robin mode: grants rotate 0,1,…,PORT_NUM-1,0. Worst-case wait is PORT_NUM-1 accepted transfers.
- Requester drops mem_rd_i before accept: no transfer and no valid. This is legal but discouraged.
- Reset asserted mid-operation: ptr and pipeline clear asynchronously. In-flight reads never raise mem_valid_o.
- Requests in the first cycle after reset release arbitrate normally with ptr = 0.

## Structure
- Shared package: ARB_FIXED = 0 and ARB_RR = 1 constants, plus the clog2 function.
- One sub-module is natural: rr_prio_pick (PORT_NUM request vector + start index → one-hot grant + binary index). It is reused by the RAM arbiter.
- The valid pipeline is a generate loop in the top module.

## Test plan
- **Fixed mode, 4 ports:** mem_rd_i = 4'b1110 with mem_accept_i = 1 held → port 1 granted every cycle, mem_addr_o = addr1. With RD_LATENCY = 2, mem_valid_o = 4'b0010 from two cycles after the first accept.
- **Round-robin, 4 ports:** all request, mem_accept_i = 1 → accepts 0,1,2,3,0 on consecutive cycles. mem_valid_o follows the same sequence delayed by RD_LATENCY.
- **Round-robin, PORT_NUM = 3:** ports 2 and 0 request, ptr = 2 → grant 2, ptr wraps to 0, next grant 0, ptr = 1.
- **Memory stall:** mem_accept_i = 0 for 3 cycles with port 3 requesting → no accept, ptr unchanged, mem_valid_o = 0. Port 3 is accepted in the first cycle mem_accept_i = 1.
- **Reset mid-flight:** accept port 2 with RD_LATENCY = 3, assert rst one cycle later → mem_valid_o stays 0; after release ptr = 0.
- **Idle:** mem_rd_i = 0 → mem_rd_o = 0, mem_addr_o = 0, mem_accept_o = 0 regardless of mem_accept_i.
